// File: rtl/storage_access_controller_pkg.sv
// rtl/storage_access_controller_pkg.sv - shared states and address map constants for the storage access sequencer
package storage_access_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_INPUT_WIDTH           = 32;
   localparam int DEF_MEMORY_ADDRESS_WIDTH  = 13;
   localparam int DEF_STORAGE_ADDRESS_WIDTH = 15;

   // Main memory sits at the bottom of the map; storage follows directly after it.
   localparam logic [31:0] STORAGE_START = 32'd1 << DEF_MEMORY_ADDRESS_WIDTH;
   localparam logic [31:0] MEMORY_END    = STORAGE_START - 32'd1;
   localparam logic [31:0] STORAGE_LIMIT = STORAGE_START + (32'd1 << DEF_STORAGE_ADDRESS_WIDTH);

   function automatic logic [63:0] storage_limit(input int mem_aw, input int sto_aw);
      return (64'd1 << mem_aw) + (64'd1 << sto_aw);
   endfunction

endpackage

// File: rtl/storage_access_controller_if.sv
// rtl/storage_access_controller_if.sv - CPU request, main memory and storage bank signal bundle
interface storage_access_controller_if #(
   parameter int INPUT_WIDTH           = 32,
   parameter int MEMORY_ADDRESS_WIDTH  = 13,
   parameter int STORAGE_ADDRESS_WIDTH = 15
) ();

   logic                             req_valid;
   logic                             req_write;
   logic [INPUT_WIDTH-1:0]           req_address;
   logic [INPUT_WIDTH-1:0]           req_wdata;
   logic                             is_storage;
   logic [STORAGE_ADDRESS_WIDTH-1:0] storage_address;
   logic                             stall;
   logic                             ack;
   logic [INPUT_WIDTH-1:0]           rdata;
   logic                             access_fault;

   logic [MEMORY_ADDRESS_WIDTH-1:0]  memory_address;
   logic                             memory_we;
   logic [INPUT_WIDTH-1:0]           memory_wdata;
   logic [INPUT_WIDTH-1:0]           memory_rdata;

   logic [STORAGE_ADDRESS_WIDTH-1:0] storage_addr;
   logic                             storage_en;
   logic                             storage_we;
   logic [INPUT_WIDTH-1:0]           storage_wdata;
   logic [INPUT_WIDTH-1:0]           storage_rdata;

   // master: CPU, decoder and memories; slave: the sequencer itself
   modport master (
      output req_valid, req_write, req_address, req_wdata, is_storage, storage_address,
      output memory_rdata, storage_rdata,
      input  stall, ack, rdata, access_fault,
      input  memory_address, memory_we, memory_wdata,
      input  storage_addr, storage_en, storage_we, storage_wdata
   );

   modport slave (
      input  req_valid, req_write, req_address, req_wdata, is_storage, storage_address,
      input  memory_rdata, storage_rdata,
      output stall, ack, rdata, access_fault,
      output memory_address, memory_we, memory_wdata,
      output storage_addr, storage_en, storage_we, storage_wdata
   );

endinterface

// File: rtl/storage_access_controller_wait_state_counter.sv
// rtl/storage_access_controller_wait_state_counter.sv - loadable down-counter that flags the last storage wait state
module wait_state_counter #(
   parameter int WAIT_STATES = 3
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic terminal
);

   localparam int CW = $clog2(WAIT_STATES + 1);

   logic [CW-1:0] count;

   // Saturates at 1 so a lingering decrement can never wrap into a long wait.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(WAIT_STATES);
      end else if (dec && (count > CW'(1))) begin
         count <= count - CW'(1);
      end
   end

   assign terminal = (count == CW'(1));

endmodule

// File: rtl/storage_access_controller.sv
// rtl/storage_access_controller.sv - sequences CPU accesses to main memory or the wait-stated storage bank
// Optional build macro: STORAGE_WRITE_PROTECT_EN turns storage stores into faults.
module storage_access_controller
   import storage_access_pkg::*;
#(
   parameter int INPUT_WIDTH           = 32,
   parameter int MEMORY_ADDRESS_WIDTH  = 13,
   parameter int STORAGE_ADDRESS_WIDTH = 15,
   parameter int STORAGE_WAIT_STATES   = 3
) (
   input  logic                       clock,
   input  logic                       reset_n,
   storage_access_controller_if.slave bus
);

   localparam logic [INPUT_WIDTH-1:0] LIMIT =
      INPUT_WIDTH'(storage_limit(MEMORY_ADDRESS_WIDTH, STORAGE_ADDRESS_WIDTH));

`ifdef STORAGE_WRITE_PROTECT_EN
   localparam bit WRITE_PROTECT = 1'b1;
`else
   localparam bit WRITE_PROTECT = 1'b0;
`endif

   state_t state, state_next;

   logic                             in_range;
   logic                             req_fault;
   logic                             req_storage;
   logic                             req_memory;
   logic                             accepting;
   logic                             cnt_load;
   logic                             cnt_dec;
   logic                             cnt_term;

   logic [STORAGE_ADDRESS_WIDTH-1:0] addr_q;
   logic [INPUT_WIDTH-1:0]           wdata_q;
   logic                             write_q;
   logic [INPUT_WIDTH-1:0]           rdata_q;
   logic                             fault_q;

   // Range check wins over the decoder flag: nothing beyond storage may strobe a port.
   assign in_range    = (bus.req_address < LIMIT);
   assign req_fault   = !in_range || (WRITE_PROTECT && bus.is_storage && bus.req_write);
   assign req_storage = !req_fault && bus.is_storage;
   assign req_memory  = !req_fault && !bus.is_storage;
   assign accepting   = bus.req_valid && (state != WAIT);

   wait_state_counter #(
      .WAIT_STATES (STORAGE_WAIT_STATES)
   ) u_wait_state_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .terminal (cnt_term)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_term) begin
               state_next = DONE;
            end
         end
         default: begin
            if (!bus.req_valid) begin
               state_next = IDLE;
            end else if (req_fault) begin
               state_next = DONE;
            end else if (req_memory) begin
               state_next = MEM;
            end else begin
               state_next = WAIT;
               cnt_load   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         if (accepting && req_storage) begin
            addr_q  <= bus.storage_address;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
         end
         if (accepting) begin
            fault_q <= req_fault;
         end
         if ((state == WAIT) && cnt_term) begin
            rdata_q <= bus.storage_rdata;
         end
      end
   end

   // Main memory is driven straight from the request so the read lands one cycle later.
   assign bus.memory_address = bus.req_address[MEMORY_ADDRESS_WIDTH-1:0];
   assign bus.memory_wdata   = bus.req_wdata;
   assign bus.memory_we      = accepting && req_memory && bus.req_write;

   assign bus.storage_addr   = addr_q;
   assign bus.storage_wdata  = wdata_q;
   assign bus.storage_en     = (state == WAIT);
   assign bus.storage_we     = (state == WAIT) && write_q;

   assign bus.stall          = (state == WAIT) || (accepting && req_storage);
   assign bus.ack            = (state == MEM) || (state == DONE);
   assign bus.access_fault   = (state == DONE) && fault_q;
   assign bus.rdata          = (state == MEM) ? bus.memory_rdata : rdata_q;

endmodule

// File: tb/tb_storage_access_controller.sv
// tb/tb_storage_access_controller.sv - directed vector bench for storage_access_controller (W = 3)
module tb_storage_access_controller;
   import storage_access_pkg::*;

   logic clock;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   storage_access_controller_if bus ();

   storage_access_controller dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef STORAGE_WRITE_PROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        is_sto;
      logic [14:0] saddr;
      logic [31:0] mrd;
      logic [31:0] srd;
      int          ack_at;
      logic [31:0] rdata;
      logic        fault;
      logic        mwe;
      int          stall_n;
      int          sen_n;
      int          swe_n;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int          ack_at;
      int          n_stall;
      int          n_sen;
      int          n_swe;
      logic [31:0] got_rdata;
      logic        got_fault;
      logic [14:0] got_saddr;
      logic [31:0] got_swdata;
      ack_at     = -1;
      n_sen      = 0;
      n_swe      = 0;
      got_rdata  = '0;
      got_fault  = 1'b0;
      got_saddr  = '0;
      got_swdata = '0;
      @(negedge clock);
      bus.req_valid       = 1'b1;
      bus.req_write       = v.write;
      bus.req_address     = v.addr;
      bus.req_wdata       = v.wdata;
      bus.is_storage      = v.is_sto;
      bus.storage_address = v.saddr;
      bus.memory_rdata    = v.mrd;
      bus.storage_rdata   = v.srd;
      #1;
      n_stall = int'(bus.stall);
      check({name, ".memory_we"}, 32'(bus.memory_we), 32'(v.mwe));
      check({name, ".memory_address"}, 32'(bus.memory_address), 32'(v.addr[12:0]));
      check({name, ".ack_at_N"}, 32'(bus.ack), 32'd0);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         bus.req_valid = 1'b0;
         #1;
         if (bus.stall) n_stall++;
         if (bus.storage_en) begin
            n_sen++;
            got_saddr  = bus.storage_addr;
            got_swdata = bus.storage_wdata;
         end
         if (bus.storage_we) n_swe++;
         if (bus.ack && (ack_at < 0)) begin
            ack_at    = c;
            got_rdata = bus.rdata;
            got_fault = bus.access_fault;
         end
      end
      check({name, ".ack_latency"}, 32'(ack_at), 32'(v.ack_at));
      check({name, ".access_fault"}, 32'(got_fault), 32'(v.fault));
      check({name, ".stall_cycles"}, 32'(n_stall), 32'(v.stall_n));
      check({name, ".storage_en_cycles"}, 32'(n_sen), 32'(v.sen_n));
      check({name, ".storage_we_cycles"}, 32'(n_swe), 32'(v.swe_n));
      if (!v.write && !v.fault) check({name, ".rdata"}, got_rdata, v.rdata);
      if (v.sen_n > 0) check({name, ".storage_addr"}, 32'(got_saddr), 32'(v.saddr));
      if (v.swe_n > 0) check({name, ".storage_wdata"}, got_swdata, v.wdata);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      //          wr    addr           wdata          sto   saddr     mrd            srd            ack rdata         flt   mwe   stl sen swe
      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 15'h0,    32'hCAFE_0001, 32'h0,         1, 32'hCAFE_0001, 1'b0, 1'b0, 0,  0,  0};
      vecs[1] = '{1'b0, 32'h0000_2004, 32'h0,         1'b1, 15'h0004, 32'h0,         32'h1234_5678, 4, 32'h1234_5678, 1'b0, 1'b0, 4,  3,  0};
      vecs[2] = '{1'b0, STORAGE_LIMIT, 32'h0,         1'b1, 15'h0,    32'h0,         32'h0,         1, 32'h0,         1'b1, 1'b0, 0,  0,  0};
      if (WP)
         vecs[3] = '{1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 15'h1000, 32'h0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 0, 0, 0};
      else
         vecs[3] = '{1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 15'h1000, 32'h0, 32'h0, 4, 32'h0, 1'b0, 1'b0, 4, 3, 3};
      vecs[4] = '{1'b1, 32'h0000_1FFC, 32'h0000_0055, 1'b0, 15'h0,    32'h0,         32'h0,         1, 32'h0,         1'b0, 1'b1, 0,  0,  0};
      vecs[5] = '{1'b0, 32'h0000_9FFC, 32'h0,         1'b1, 15'h7FFC, 32'h0,         32'hA5A5_5A5A, 4, 32'hA5A5_5A5A, 1'b0, 1'b0, 4,  3,  0};
      vecs[6] = '{1'b0, MEMORY_END,    32'h0,         1'b0, 15'h0,    32'h0BAD_F00D, 32'h0,         1, 32'h0BAD_F00D, 1'b0, 1'b0, 0,  0,  0};
      vecs[7] = '{1'b1, 32'hFFFF_FFF0, 32'h7777_7777, 1'b0, 15'h0,    32'h0,         32'h0,         1, 32'h0,         1'b1, 1'b0, 0,  0,  0};
      vecs[8] = '{1'b0, STORAGE_START, 32'h0,         1'b1, 15'h0000, 32'h0,         32'h0F0F_1E1E, 4, 32'h0F0F_1E1E, 1'b0, 1'b0, 4,  3,  0};

      bus.req_valid       = 1'b0;
      bus.req_write       = 1'b0;
      bus.req_address     = '0;
      bus.req_wdata       = '0;
      bus.is_storage      = 1'b0;
      bus.storage_address = '0;
      bus.memory_rdata    = '0;
      bus.storage_rdata   = '0;
      reset_n             = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("reset.stall", 32'(bus.stall), 32'd0);
      check("reset.ack", 32'(bus.ack), 32'd0);
      check("reset.access_fault", 32'(bus.access_fault), 32'd0);
      check("reset.storage_en", 32'(bus.storage_en), 32'd0);
      check("reset.storage_we", 32'(bus.storage_we), 32'd0);
      check("reset.memory_we", 32'(bus.memory_we), 32'd0);
      check("reset.rdata", bus.rdata, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset during the second wait state: strobes drop at once and no ack follows.
      @(negedge clock);
      bus.req_valid       = 1'b1;
      bus.req_write       = 1'b0;
      bus.req_address     = 32'h0000_2040;
      bus.is_storage      = 1'b1;
      bus.storage_address = 15'h0040;
      bus.storage_rdata   = 32'h5555_AAAA;
      @(negedge clock);
      bus.req_valid = 1'b0;
      @(negedge clock);
      #1;
      check("midwait.storage_en_before", 32'(bus.storage_en), 32'd1);
      reset_n = 1'b0;
      #1;
      check("midwait.storage_en_async", 32'(bus.storage_en), 32'd0);
      check("midwait.stall_async", 32'(bus.stall), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      begin
         int acks;
         acks = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            #1;
            if (bus.ack) acks++;
         end
         check("midwait.no_ack", 32'(acks), 32'd0);
      end
      run_vec(vecs[0], "after_reset");

      // Back-to-back memory loads: the second request rides the first's MEM cycle.
      @(negedge clock);
      bus.req_valid   = 1'b1;
      bus.req_write   = 1'b0;
      bus.is_storage  = 1'b0;
      bus.req_address = 32'h0000_0020;
      #1;
      check("b2b.stall_n", 32'(bus.stall), 32'd0);
      @(negedge clock);
      bus.req_address  = 32'h0000_0024;
      bus.memory_rdata = 32'h1111_0020;
      #1;
      check("b2b.ack_n1", 32'(bus.ack), 32'd1);
      check("b2b.rdata_n1", bus.rdata, 32'h1111_0020);
      check("b2b.stall_n1", 32'(bus.stall), 32'd0);
      @(negedge clock);
      bus.req_valid    = 1'b0;
      bus.memory_rdata = 32'h2222_0024;
      #1;
      check("b2b.ack_n2", 32'(bus.ack), 32'd1);
      check("b2b.rdata_n2", bus.rdata, 32'h2222_0024);
      @(negedge clock);
      #1;
      check("b2b.ack_n3", 32'(bus.ack), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/storage_access_controller.md
# storage_access_controller

Sequencer downstream of the address decoder. It consumes the decoder's `is_storage`/`storage_address` outputs for each CPU load/store and drives either the single-cycle main memory or the slower storage bank. Storage accesses take a fixed number of wait states, during which the CPU is stalled. It returns read data with a one-cycle `ack` and flags out-of-range accesses.

## Interface
- `INPUT_WIDTH`, 32: CPU address and data width.
- `MEMORY_ADDRESS_WIDTH`, 13: main memory word address width.
- `STORAGE_ADDRESS_WIDTH`, 15: storage word address width.
- `STORAGE_WAIT_STATES`, 3: cycles `storage_en` is held before data is sampled; legal range 1..15.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: CPU access request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_address` in INPUT_WIDTH: original CPU address.
- `req_wdata` in INPUT_WIDTH: store data.
- `is_storage` in 1: decoder output for `req_address`.
- `storage_address` in STORAGE_ADDRESS_WIDTH: decoder output, `req_address - STORAGE_START`.
- `stall` out 1: CPU must hold request and pipeline.
- `ack` out 1: one-cycle pulse when the access completes.
- `rdata` out INPUT_WIDTH: load result, valid while `ack` is high and the access was a load.
- `access_fault` out 1: one-cycle pulse together with `ack` on a rejected access.
- `memory_address` out MEMORY_ADDRESS_WIDTH, `memory_we` out 1, `memory_wdata` out INPUT_WIDTH, `memory_rdata` in INPUT_WIDTH: synchronous RAM port, 1-cycle read.
- `storage_addr` out STORAGE_ADDRESS_WIDTH, `storage_en` out 1, `storage_we` out 1, `storage_wdata` out INPUT_WIDTH, `storage_rdata` in INPUT_WIDTH: storage port.

## Operation
- States are IDLE, MEM, WAIT and DONE.
- **IDLE**
  - `req_valid` with `!is_storage` -> MEM. Drive `memory_address = req_address[MEMORY_ADDRESS_WIDTH-1:0]` and `memory_we = req_write` combinationally in the same cycle.
  - `req_valid` with `is_storage` and `req_address < STORAGE_LIMIT` (= STORAGE_START + 2^STORAGE_ADDRESS_WIDTH) -> WAIT. Latch address, wdata and write into registers. Load the counter with STORAGE_WAIT_STATES.
  - `req_valid` with `req_address >= STORAGE_LIMIT` -> DONE with a fault flag. No memory or storage strobe is driven.
- **MEM**: `ack` is high. `rdata = memory_rdata`. Returns to IDLE, or accepts a new request in the same cycle (back-to-back).
- **WAIT**
  - `storage_en` is high. `storage_we` equals the latched write bit.
  - Counter decrements each cycle.
  - At count 1, `storage_rdata` is sampled into the `rdata` register -> DONE.
- **DONE**: `ack` is high, plus `access_fault` if flagged. Accepts a new request exactly as IDLE does.
- `stall` is combinational: high in WAIT, and in IDLE/MEM/DONE when `req_valid && is_storage` (address in range) is presented. It is low otherwise.
- Requests arriving while in WAIT are ignored; the requester holds them under `stall`.
- The counter is `$clog2(STORAGE_WAIT_STATES+1)` bits and never wraps below 1.

## Timing
- Reset values: state IDLE, counter 0, `rdata` 0. `stall`, `ack`, `access_fault`, `memory_we`, `storage_en` and `storage_we` are all 0.
- Memory access accepted at cycle N -> `ack` at N+1, zero stall cycles.
- Storage access accepted at N:
  - `storage_en` is high for N+1..N+W (W = STORAGE_WAIT_STATES).
  - `ack` and `rdata` appear at N+W+1.
  - `stall` is high for N..N+W.
- Fault accepted at N -> `ack` and `access_fault` at N+1, no stall.
- Reset asserted mid-WAIT: `storage_en`/`storage_we` drop immediately (asynchronously). No `ack` is issued and the access is abandoned.
- A new request presented in the DONE/MEM cycle is accepted. Throughput is 1 access per cycle for main memory.

## Configuration
- `STORAGE_WRITE_PROTECT_EN`
  - Defined: a storage store (`is_storage && req_write`) is treated as a fault. It goes to DONE with `access_fault`, `storage_we` is never asserted, and there is no stall.
  - Undefined: storage stores run the normal WAIT sequence with `storage_we` high for all W cycles.
  - Main memory stores are unaffected in both cases.

## Structure
- `storage_access_pkg` holds:
  - the state enum (IDLE, MEM, WAIT, DONE);
  - the constants STORAGE_START (2^MEMORY_ADDRESS_WIDTH), MEMORY_END (STORAGE_START-1) and STORAGE_LIMIT, shared with the address decoder.
- Sub-module `wait_state_counter` handles the load/decrement/terminal-count flag. Width is derived from STORAGE_WAIT_STATES.

## Test plan
- Load 0x0000_0010, `memory_rdata`=0xCAFE_0001 -> `ack` at N+1, `rdata`=0xCAFE_0001, `stall` never high.
- Load 0x0000_2004 (W=3), `storage_rdata`=0x1234_5678 -> `storage_addr`=0x0004, `stall` for 4 cycles, `ack` at N+4 with `rdata`=0x1234_5678.
- Load 0x0000_A000 (≥ STORAGE_LIMIT 0xA000) -> `ack` and `access_fault` at N+1, `storage_en`/`memory_we` stay 0.
- Store 0x0000_3000 data 0xDEAD_BEEF:
  - macro undefined: `storage_we` is high for 3 cycles with `storage_wdata`=0xDEAD_BEEF;
  - macro defined: `access_fault` at N+1 and `storage_we` stays 0.
- `reset_n` low during the 2nd WAIT cycle -> `storage_en`=0 the same cycle, no `ack`. After release, a memory load completes normally.
- Back-to-back memory loads at N and N+1 -> `ack` at N+1 and N+2 with the respective data.
